// File: rtl/absdiff_share_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | absdiff_share_arb: round-robin sharing of one registered |a-b| unit         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module absdiff_share_arb #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*DW-1:0]   req_a,
    input  logic [N_REQ*DW-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  res_valid,
    output logic [DW:0]           res_data,
    output logic [ID_W-1:0]       res_id,
    input  logic                  res_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            res_valid_q, res_valid_d;
    logic [DW:0]     res_data_q, res_data_d;
    logic [ID_W-1:0] res_id_q, res_id_d;

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [DW-1:0]    sel_a;
    logic [DW-1:0]    sel_b;
    logic [N_REQ-1:0] req_ready_w;
    int               idx;

    // Circular priority search starting at rr_ptr; the first hit wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_a       = '0;
        sel_b       = '0;
        idx         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
                sel_a       = req_a[idx*DW +: DW];
                sel_b       = req_b[idx*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        req_ready_w = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready_w[grant_idx] = 1'b1;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    id_d    = grant_idx;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                res_data_d  = (a_q > b_q) ? {1'b0, a_q - b_q} : {1'b0, b_q - a_q};
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    // Pointer moves only on handoff so a stalled consumer cannot skew fairness.
                    rr_ptr_d    = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign req_ready = rst ? '0 : req_ready_w;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule
`default_nettype wire

// File: tb/tb_absdiff_share_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_absdiff_share_arb: randomized bench with round-robin |a-b| model         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_absdiff_share_arb;
    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int ID_W  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_a;
    logic [N_REQ*DW-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic                res_valid;
    logic [DW:0]         res_data;
    logic [ID_W-1:0]     res_id;
    logic                res_ready;

    int checks = 0;
    int errors = 0;
    int ptr    = 0;   // model of the round-robin start index

    always #5 clk = ~clk;

    absdiff_share_arb #(.N_REQ(N_REQ), .DW(DW), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [N_REQ-1:0] mask, input int start);
        for (int k = 0; k < N_REQ; k++)
            if (mask[(start + k) % N_REQ]) return (start + k) % N_REQ;
        return -1;
    endfunction

    task automatic scramble();
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*DW +: DW] = DW'($urandom);
            req_b[i*DW +: DW] = DW'($urandom);
        end
    endtask

    // One complete operation starting from IDLE; fixed operands go to every lane when use_fix=1.
    task automatic op(input logic [N_REQ-1:0] mask, input bit use_fix,
                      input int fa, input int fb, input int stall);
        int g, ea, eb, ed;
        logic [DW:0] held_d;
        logic [ID_W-1:0] held_id;
        @(negedge clk);
        scramble();
        if (use_fix)
            for (int i = 0; i < N_REQ; i++) begin
                req_a[i*DW +: DW] = DW'(fa);
                req_b[i*DW +: DW] = DW'(fb);
            end
        req_valid = mask;
        res_ready = (stall == 0);
        #1;
        chk("idle_res_valid", 32'(res_valid), 0);
        g = model_grant(mask, ptr);
        if (g < 0) begin
            chk("idle_no_grant", 32'(req_ready), 0);
            return;
        end
        chk("grant_onehot", 32'(req_ready), 32'(1) << g);
        ea = int'(req_a[g*DW +: DW]);
        eb = int'(req_b[g*DW +: DW]);
        ed = (ea > eb) ? ea - eb : eb - ea;
        @(negedge clk);
        scramble();
        req_valid = 4'($urandom);
        #1;
        chk("calc_ready", 32'(req_ready), 0);
        chk("calc_res_valid", 32'(res_valid), 0);
        @(negedge clk);
        req_valid = 4'($urandom);
        #1;
        chk("resp_valid", 32'(res_valid), 1);
        chk("resp_data", 32'(res_data), 32'(ed));
        chk("resp_id", 32'(res_id), 32'(g));
        chk("resp_ready", 32'(req_ready), 0);
        held_d  = res_data;
        held_id = res_id;
        for (int s = 1; s < stall; s++) begin
            @(negedge clk);
            scramble();
            #1;
            chk("stall_valid", 32'(res_valid), 1);
            chk("stall_data", 32'(res_data), 32'(held_d));
            chk("stall_id", 32'(res_id), 32'(held_id));
            chk("stall_ready", 32'(req_ready), 0);
        end
        res_ready = 1'b1;
        ptr = (g + 1) % N_REQ;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        ptr = 0;

        op(4'b0001, 1, 200, 55, 0);          // 145 from requester 0
        op(4'b0010, 1, 3, 250, 0);           // 247 from requester 1
        op(4'b0010, 1, 8'h80, 8'h80, 0);     // equal operands
        op(4'b0000, 0, 0, 0, 0);             // nothing to grant
        for (int n = 0; n < 5; n++) op(4'b1111, 0, 0, 0, 0);
        op(4'b1111, 0, 0, 0, 6);             // consumer stalls for 5 cycles
        op(4'b1111, 1, 255, 0, 0);           // maximum difference

        // Reset while the unit is computing: no result may appear.
        @(negedge clk);
        req_valid = 4'b1111;
        scramble();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_calc_valid", 32'(res_valid), 0);
        chk("rst_calc_ready", 32'(req_ready), 0);
        @(negedge clk);
        #1;
        chk("rst_hold_valid", 32'(res_valid), 0);
        rst = 1'b0;
        req_valid = '0;
        ptr = 0;
        op(4'b1100, 0, 0, 0, 0);             // grants 2
        op(4'b0100, 0, 0, 0, 0);             // wrap-around from 3 back to 2
        op(4'b1001, 0, 0, 0, 0);             // pointer at 3 again

        for (int n = 0; n < 40; n++)
            op(4'($urandom), 0, 0, 0, int'($urandom_range(0, 3)));

        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
